// File: rtl/mem_arbiter.sv
// Two-port SRAM access arbiter: one access per grant, serialised onto mem cmd/addr/data.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with a starvation guard.
package mem_arbiter_pkg;
  typedef logic [15:0] addr_t;
  typedef enum logic {CMD_READ = 1'b0, CMD_WRITE0 = 1'b1} cmd_t;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int READ_WAIT    = 1,
  parameter int WRITE_CYCLES = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  addr_t       req0_addr,
  input  logic [7:0]  req0_wdata,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [7:0]  req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  addr_t       req1_addr,
  input  logic [7:0]  req1_wdata,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [7:0]  req1_rdata,
  output cmd_t        mem_cmd,
  output addr_t       mem_addr,
  output logic [7:0]  mem_write_data,
  input  logic [7:0]  mem_read_data,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds valid and its fields stable; reqN_ready is a
  // registered one-cycle pulse and the fields are captured at the end of that
  // pulse cycle. Dropping valid before ready appears withdraws the request.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam int MAXC = (READ_WAIT > WRITE_CYCLES) ? READ_WAIT : WRITE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          pend;
  logic          pend_port;
  logic          cur_port;
  logic          arb_en;
  logic          any_valid;
  logic          pick1;
  logic          last_cycle;

  assign any_valid  = req0_valid | req1_valid;
  assign last_cycle = (cnt == CW'(1));
  // Arbitration for the next access overlaps the final cycle of the current one,
  // so back-to-back reads take 1+READ_WAIT cycles and writes 2+WRITE_CYCLES.
  assign arb_en = ((state == ST_IDLE) && !pend) ||
                  ((state == ST_RD) && last_cycle) ||
                  (state == ST_TURN);
  assign dbg_state = state;

`ifdef MEM_ARB_RR_EN
  logic last_win;

  assign pick1 = req1_valid && (!req0_valid || !last_win);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_win <= 1'b1;
    end else if (arb_en && any_valid) begin
      last_win <= pick1;
    end
  end
`else
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (STARVE_LIMIT != 0) && (starve_cnt == SW'(STARVE_LIMIT));
  assign pick1   = req1_valid && (!req0_valid || starved);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!req1_valid && (arb_en || (state == ST_IDLE))) begin
      starve_cnt <= '0;
    end else if (arb_en && any_valid) begin
      if (pick1) begin
        starve_cnt <= '0;
      end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pend           <= 1'b0;
      pend_port      <= 1'b0;
      cur_port       <= 1'b0;
      mem_cmd        <= CMD_READ;
      mem_addr       <= '0;
      mem_write_data <= '0;
      req0_ready     <= 1'b0;
      req1_ready     <= 1'b0;
      req0_rvalid    <= 1'b0;
      req1_rvalid    <= 1'b0;
      req0_rdata     <= '0;
      req1_rdata     <= '0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;

      if (arb_en && any_valid) begin
        pend      <= 1'b1;
        pend_port <= pick1;
        req0_ready <= !pick1;
        req1_ready <= pick1;
      end

      case (state)
        ST_IDLE: begin
          if (pend) begin
            pend           <= 1'b0;
            cur_port       <= pend_port;
            mem_addr       <= pend_port ? req1_addr : req0_addr;
            mem_write_data <= pend_port ? req1_wdata : req0_wdata;
            if (pend_port ? req1_we : req0_we) begin
              state   <= ST_WR;
              mem_cmd <= CMD_WRITE0;
              cnt     <= CW'(WRITE_CYCLES);
            end else begin
              state <= ST_RD;
              cnt   <= CW'(READ_WAIT);
            end
          end
        end
        ST_RD: begin
          if (last_cycle) begin
            state <= ST_IDLE;
            if (cur_port) begin
              req1_rdata  <= mem_read_data;
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= mem_read_data;
              req0_rvalid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_WR: begin
          if (last_cycle) begin
            state   <= ST_TURN;
            mem_cmd <= CMD_READ;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single read/write, arbitration order,
// reset during a write and request withdrawal, against a behavioural SRAM.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  logic       req0_valid, req0_we, req0_ready, req0_rvalid;
  addr_t      req0_addr;
  logic [7:0] req0_wdata, req0_rdata;
  logic       req1_valid, req1_we, req1_ready, req1_rvalid;
  addr_t      req1_addr;
  logic [7:0] req1_wdata, req1_rdata;
  cmd_t       mem_cmd;
  addr_t      mem_addr;
  logic [7:0] mem_write_data, mem_read_data;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sram [0:65535];
  logic [8:0] exp_q [$];

  mem_arbiter #(.READ_WAIT(1), .WRITE_CYCLES(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read, write on the edge while WRITE0 is driven
  assign mem_read_data = sram[mem_addr];
  always @(posedge clk) begin
    if (mem_cmd == CMD_WRITE0) sram[mem_addr] <= mem_write_data;
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic idle_inputs;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (mem_cmd !== CMD_READ) begin failures++; $display("FAIL reset_cmd: got %0d expected %0d", mem_cmd, CMD_READ); end
    checks++;
    if (mem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    checks++;
    if ({req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 4'b0000) begin
      failures++; $display("FAIL reset_pulses: got %b expected 0000", {req0_ready, req1_ready, req0_rvalid, req1_rvalid});
    end
    checks++;
    if ({req0_rdata, req1_rdata} !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %0h expected 0", {req0_rdata, req1_rdata}); end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 4'b0000 || dbg_state !== 2'd0) begin
        failures++; $display("FAIL post_reset_idle: got pulses=%b state=%0d expected 0000/0",
                             {req0_ready, req1_ready, req0_rvalid, req1_rvalid}, dbg_state);
      end
    end
  endtask

  task automatic test_port0_read;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0123;
    tick();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL rd_ready_c0: got r0=%b r1=%b expected 1/0", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if (mem_addr !== 16'h0123 || mem_cmd !== CMD_READ || req0_ready !== 1'b0) begin
      failures++; $display("FAIL rd_addr_c1: got addr=%0h cmd=%0d ready=%b expected 123/0/0", mem_addr, mem_cmd, req0_ready);
    end
    tick();
    checks++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 8'hA5) begin
      failures++; $display("FAIL rd_rvalid_c2: got rvalid=%b rdata=%0h expected 1/a5", req0_rvalid, req0_rdata);
    end
    tick();
    checks++;
    if (req0_rvalid !== 1'b0 || req0_rdata !== 8'hA5) begin
      failures++; $display("FAIL rd_hold_c3: got rvalid=%b rdata=%0h expected 0/a5", req0_rvalid, req0_rdata);
    end
  endtask

  task automatic test_port1_write;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 16'h0040; req1_wdata = 8'h5A;
    tick();
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++; $display("FAIL wr_ready_c0: got r1=%b r0=%b expected 1/0", req1_ready, req0_ready);
    end
    tick();
    req1_valid = 1'b0; req1_we = 1'b0;
    checks++;
    if (mem_cmd !== CMD_WRITE0 || mem_addr !== 16'h0040 || mem_write_data !== 8'h5A) begin
      failures++; $display("FAIL wr_c1: got cmd=%0d addr=%0h data=%0h expected 1/40/5a", mem_cmd, mem_addr, mem_write_data);
    end
    tick();
    checks++;
    if (mem_cmd !== CMD_READ || dbg_state !== 2'd3 || req1_rvalid !== 1'b0) begin
      failures++; $display("FAIL wr_turn_c2: got cmd=%0d state=%0d rvalid=%b expected 0/3/0", mem_cmd, dbg_state, req1_rvalid);
    end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0040;
    tick();
    checks++;
    if (req0_ready !== 1'b1 || req1_rvalid !== 1'b0) begin
      failures++; $display("FAIL wr_next_ready: got ready0=%b rvalid1=%b expected 1/0", req0_ready, req1_rvalid);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 8'h5A) begin
      failures++; $display("FAIL wr_readback: got rvalid=%b rdata=%0h expected 1/5a", req0_rvalid, req0_rdata);
    end
  endtask

  task automatic test_arbitration;
    int exp_order [10];
    int n_gnt;
    int last_c;
    bit drop_pending;
    logic [8:0] got;
    logic [8:0] want;
`ifdef MEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    apply_reset();
    n_gnt = 0; last_c = -1; drop_pending = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0020;
    for (int c = 0; c < 26; c++) begin
      tick();
      if (drop_pending) begin
        req0_valid = 1'b0; req1_valid = 1'b0; drop_pending = 1'b0;
      end
      if (req0_rvalid || req1_rvalid) begin
        got = {req1_rvalid, req1_rvalid ? req1_rdata : req0_rdata};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        checks++;
        if (got !== want || (req0_rvalid && req1_rvalid)) begin
          failures++; $display("FAIL arb_rdata: got port/data=%0h expected %0h", got, want);
        end
      end
      if (req0_ready || req1_ready) begin
        checks++;
        if (n_gnt >= 10 || (req0_ready && req1_ready) || int'(req1_ready) != exp_order[n_gnt]) begin
          failures++; $display("FAIL arb_order: grant %0d got port %0d expected %0d", n_gnt, req1_ready,
                               (n_gnt < 10) ? exp_order[n_gnt] : -1);
        end
        if (last_c >= 0) begin
          checks++;
          if (c - last_c != 2) begin failures++; $display("FAIL arb_period: got %0d expected 2", c - last_c); end
        end
        exp_q.push_back({req1_ready, req1_ready ? 8'h1C : 8'h2C});
        last_c = c;
        n_gnt++;
        if (n_gnt == 10) drop_pending = 1'b1;
      end
    end
    checks++;
    if (n_gnt != 10 || exp_q.size() != 0) begin
      failures++; $display("FAIL arb_count: got grants=%0d pending=%0d expected 10/0", n_gnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_write;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'h0050; req0_wdata = 8'h77;
    tick();
    tick();
    req0_valid = 1'b0; req0_we = 1'b0;
    checks++;
    if (mem_cmd !== CMD_WRITE0) begin failures++; $display("FAIL rst_wr_setup: got cmd=%0d expected 1", mem_cmd); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_cmd !== CMD_READ || dbg_state !== 2'd0 || mem_addr !== 16'h0000) begin
      failures++; $display("FAIL rst_async: got cmd=%0d state=%0d addr=%0h expected 0/0/0", mem_cmd, dbg_state, mem_addr);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req0_ready, req1_ready, req0_rvalid, req1_rvalid} !== 4'b0000 || req0_rdata !== 8'h00) begin
        failures++; $display("FAIL rst_quiet: got pulses=%b rdata0=%0h expected 0000/0",
                             {req0_ready, req1_ready, req0_rvalid, req1_rvalid}, req0_rdata);
      end
    end
    req0_valid = 1'b1; req0_addr = 16'h0123;
    tick();
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if (req0_rvalid !== 1'b1 || req0_rdata !== 8'hA5) begin
      failures++; $display("FAIL rst_recover_read: got rvalid=%b rdata=%0h expected 1/a5", req0_rvalid, req0_rdata);
    end
  endtask

  task automatic test_withdraw;
    bit saw_p0;
    saw_p0 = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0020;
    tick();
    checks++;
    if (req1_ready !== 1'b1) begin failures++; $display("FAIL wd_ready1: got %b expected 1", req1_ready); end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0010;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (req0_ready || req0_rvalid) saw_p0 = 1'b1;
    tick();
    checks++;
    if (req1_rvalid !== 1'b1 || req1_rdata !== 8'h1C) begin
      failures++; $display("FAIL wd_rvalid1: got rvalid=%b rdata=%0h expected 1/1c", req1_rvalid, req1_rdata);
    end
    if (req0_ready || req0_rvalid) saw_p0 = 1'b1;
    repeat (2) begin
      tick();
      if (req0_ready || req0_rvalid) saw_p0 = 1'b1;
    end
    checks++;
    if (saw_p0 !== 1'b0) begin failures++; $display("FAIL wd_no_grant0: got %b expected 0", saw_p0); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) sram[i] = 8'(i) ^ 8'h3C;
    sram[16'h0123] = 8'hA5;
    test_reset();
    test_port0_read();
    test_port1_write();
    test_arbitration();
    test_reset_mid_write();
    test_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
